// File: rtl/mem_sram_arbiter.sv
// mem_sram_arbiter
//
// Shares one SRAM-like port between the instruction-fetch requester and the
// memory-stage data requester. Each access is a two-phase transaction
// (address, then data). Completed results are held until the pipeline is
// released, and `stall` freezes the pipeline while any request is unserved.
//
// Build option:
//   ARB_DATA_PRIO_EN  defined: data requester wins a simultaneous request.
//                     undefined: instruction requester wins.
//
// Ports:
//   clk, reset                  pipeline clock, synchronous active-high reset
//   inst_req/addr               fetch request (held until stall=0)
//   inst_rdata/valid            fetched word, held while inst_valid
//   data_req/wr/size/addr/wdata load/store request (held until stall=0)
//   data_rdata/valid            load data, held while data_valid
//   sram_req/wr/size/addr/wdata memory request fields, stable until accepted
//   sram_addr_ok                request accepted this cycle
//   sram_data_ok, sram_rdata    response this cycle (read data or write ack)
//   stall                       freeze all pipeline registers

module mem_sram_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_valid,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_valid,
  output logic              sram_req,
  output logic              sram_wr,
  output logic [1:0]        sram_size,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [31:0]       sram_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {StIdle, StAddr, StWait} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = data requester owns the transaction
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic [31:0]       inst_rdata_q, inst_rdata_d;
  logic [31:0]       data_rdata_q, data_rdata_d;

  logic inst_pend, data_pend, pick_data, complete;

  assign inst_pend = inst_req & ~inst_done_q;
  assign data_pend = data_req & ~data_done_q;
  assign stall     = inst_pend | data_pend;

`ifdef ARB_DATA_PRIO_EN
  assign pick_data = data_pend;
`else
  assign pick_data = data_pend & ~inst_pend;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_done_d  = inst_done_q;
    data_done_d  = data_done_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    complete     = 1'b0;
    sram_req     = 1'b0;

    case (state_q)
      StIdle: begin
        if (inst_pend || data_pend) begin
          owner_d = pick_data;
          state_d = StAddr;
          if (pick_data) begin
            wr_d    = data_wr;
            size_d  = data_size;
            addr_d  = data_addr;
            wdata_d = data_wdata;
          end else begin
            wr_d    = 1'b0;
            size_d  = 2'd2;
            addr_d  = inst_addr;
            wdata_d = '0;
          end
        end
      end
      StAddr: begin
        sram_req = 1'b1;
        if (sram_addr_ok) begin
          if (sram_data_ok) begin
            complete = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (sram_data_ok) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pipeline advanced this cycle: results have been consumed.
    if (!stall) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
    end

    if (complete) begin
      if (owner_q) begin
        data_done_d = 1'b1;
        if (!wr_q) data_rdata_d = sram_rdata;
      end else begin
        inst_done_d  = 1'b1;
        inst_rdata_d = sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign sram_wr    = wr_q;
  assign sram_size  = size_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_valid = inst_done_q;
  assign data_valid = data_done_q;

endmodule

// File: tb/tb_mem_sram_arbiter.sv
// Scoreboard bench for mem_sram_arbiter: directed stimulus pushes expected
// read data into per-requester queues; a monitor pops on each rising valid.

module tb_mem_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        sram_req;
  logic        sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_addr_ok;
  logic        sram_data_ok;
  logic [31:0] sram_rdata;
  logic        stall;

  int errors = 0;
  int checks = 0;

  logic [31:0] inst_q[$];
  logic [31:0] data_q[$];
  logic        inst_valid_prev = 1'b0;
  logic        data_valid_prev = 1'b0;

  always #5 clk = ~clk;

  mem_sram_arbiter #(.ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_valid   (inst_valid),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_valid   (data_valid),
    .sram_req     (sram_req),
    .sram_wr      (sram_wr),
    .sram_size    (sram_size),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_addr_ok (sram_addr_ok),
    .sram_data_ok (sram_data_ok),
    .sram_rdata   (sram_rdata),
    .stall        (stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare held rdata on every rising valid against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (inst_valid && !inst_valid_prev) begin
      if (inst_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL inst_valid_unexpected: got valid=1 expected no result at %0t", $time);
      end else begin
        e = inst_q.pop_front();
        chk("inst_rdata", inst_rdata, e);
      end
    end
    if (data_valid && !data_valid_prev) begin
      if (data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_valid_unexpected: got valid=1 expected no result at %0t", $time);
      end else begin
        e = data_q.pop_front();
        chk("data_rdata", data_rdata, e);
      end
    end
    inst_valid_prev = inst_valid;
    data_valid_prev = data_valid;
  end

  // Advance to the next cycle's drive point (negedge), inputs change here.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic oks(input logic a, input logic d, input logic [31:0] rd);
    sram_addr_ok = a;
    sram_data_ok = d;
    sram_rdata   = rd;
  endtask

  initial begin
    logic [31:0] first_addr, second_addr;
    logic        first_is_data;
    logic [35:0] fields;

    reset = 1'b1;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = '0; data_wdata = '0;
    oks(0, 0, '0);
    repeat (3) cyc();
    #1;
    chk("rst_sram_req", sram_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valids", {inst_valid, data_valid}, 0);
    chk("rst_rdata", {inst_rdata, data_rdata}, 0);
    chk("rst_sram_fields", {sram_wr, sram_size, sram_addr, sram_wdata}, 0);
    cyc(); reset = 1'b0;

    // Single zero-wait fetch.
    cyc(); inst_req = 1; inst_addr = 32'hBFC00000; inst_q.push_back(32'h24080001);
    #1; chk("t1_c0_stall", stall, 1); chk("t1_c0_sram_req", sram_req, 0);
    cyc(); oks(1, 1, 32'h24080001);
    #1; chk("t1_c1_sram_req", sram_req, 1); chk("t1_c1_addr", sram_addr, 32'hBFC00000);
    chk("t1_c1_wr_size", {sram_wr, sram_size}, {1'b0, 2'd2}); chk("t1_c1_stall", stall, 1);
    cyc(); oks(0, 0, '0);
    #1; chk("t1_c2_valid", inst_valid, 1); chk("t1_c2_stall", stall, 0);
    cyc(); inst_req = 0;
    #1; chk("t1_c3_valid", inst_valid, 0); chk("t1_c3_stall", stall, 0);

    // Simultaneous fetch and load word.
`ifdef ARB_DATA_PRIO_EN
    first_is_data = 1'b1;
`else
    first_is_data = 1'b0;
`endif
    first_addr  = first_is_data ? 32'h80000010 : 32'hBFC00004;
    second_addr = first_is_data ? 32'hBFC00004 : 32'h80000010;
    cyc();
    inst_req = 1; inst_addr = 32'hBFC00004;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80000010;
    inst_q.push_back(32'h8C880000);
    data_q.push_back(32'h12345678);
    #1; chk("t2_c0_stall", stall, 1);
    cyc(); oks(1, 1, first_is_data ? 32'h12345678 : 32'h8C880000);
    #1; chk("t2_first_addr", sram_addr, first_addr);
    cyc(); oks(0, 0, '0);
    #1; chk("t2_first_valid", first_is_data ? data_valid : inst_valid, 1);
    chk("t2_second_not_valid", first_is_data ? inst_valid : data_valid, 0);
    chk("t2_c2_stall", stall, 1);
    cyc(); oks(1, 1, first_is_data ? 32'h8C880000 : 32'h12345678);
    #1; chk("t2_second_addr", sram_addr, second_addr);
    chk("t2_first_held", first_is_data ? data_valid : inst_valid, 1);
    cyc(); oks(0, 0, '0);
    #1; chk("t2_both_valid", {inst_valid, data_valid}, 2'b11); chk("t2_final_stall", stall, 0);
    cyc(); inst_req = 0; data_req = 0;
    #1; chk("t2_released", {inst_valid, data_valid, stall}, 0);

    // Store byte: rdata must keep the previous load value.
    cyc();
    data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h80000003;
    data_wdata = 32'h000000AB;
    data_q.push_back(32'h12345678);
    cyc(); oks(1, 0, 32'hDEADBEEF);
    #1; chk("t3_sram_wr", sram_wr, 1); chk("t3_sram_size", sram_size, 0);
    chk("t3_sram_wdata", sram_wdata, 32'h000000AB); chk("t3_sram_addr", sram_addr, 32'h80000003);
    cyc(); oks(0, 1, 32'hDEADBEEF);
    #1; chk("t3_wait_req", sram_req, 0); chk("t3_wait_valid", data_valid, 0);
    cyc(); oks(0, 0, '0);
    #1; chk("t3_valid", data_valid, 1); chk("t3_stall", stall, 0);
    cyc(); data_req = 0; data_wr = 0;

    // Delayed addr_ok (3 cycles) then data_ok 2 cycles later.
    cyc(); inst_req = 1; inst_addr = 32'hBFC00008; inst_q.push_back(32'h3C1DBFC0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 4) oks(1, 0, '0);
      #1; fields = {sram_req, sram_wr, sram_size, sram_addr};
      chk("t4_stable_fields", fields, {1'b1, 1'b0, 2'd2, 32'hBFC00008});
    end
    cyc(); oks(0, 0, '0);
    #1; chk("t4_wait_req", sram_req, 0); chk("t4_wait_valid", inst_valid, 0);
    cyc(); oks(0, 1, 32'h3C1DBFC0);
    #1; chk("t4_c6_valid", inst_valid, 0);
    cyc(); oks(0, 0, '0);
    #1; chk("t4_c7_valid", inst_valid, 1); chk("t4_c7_stall", stall, 0);
    cyc(); inst_req = 0;

    // Reset while in WAIT; a late data_ok afterwards must be ignored.
    cyc(); data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80000020;
    cyc(); oks(1, 0, '0);
    cyc(); oks(0, 0, '0); reset = 1'b1; data_req = 0;
    cyc(); reset = 1'b0; oks(0, 1, 32'h55555555);
    #1; chk("t5_sram_req", sram_req, 0); chk("t5_valid", data_valid, 0);
    chk("t5_stall", stall, 0); chk("t5_rdata_cleared", data_rdata, 0);
    cyc(); oks(0, 0, '0);
    #1; chk("t5_late_ok_valid", data_valid, 0); chk("t5_late_ok_rdata", data_rdata, 0);
    chk("t5_idle_req", sram_req, 0);

    repeat (2) cyc();
    #3;
    chk("queues_drained", inst_q.size() + data_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
